// File: rtl/reg_write_arbiter_if.sv
// +-------------------------------------------------------------------------+
// | reg_write_arbiter_if : request/grant/write bus of the shared register   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface reg_write_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         out;
  logic [2:0]               owner;
  logic                     owner_valid;
  logic                     locked;

  modport master (
    output req, lock, wdata,
    input  gnt, out, owner, owner_valid, locked
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, out, owner, owner_valid, locked
  );
endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// +-------------------------------------------------------------------------+
// | reg_write_arbiter : round-robin write arbiter with bounded lock bursts  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module reg_write_arbiter #(
  parameter int               WIDTH    = 8,
  parameter int               NUM_REQ  = 4,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int               MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [3:0]       r_hold;
  logic [2:0]       r_lk_id;
  logic [WIDTH-1:0] r_out;
  logic [2:0]       r_owner;
  logic             r_valid;
  logic             r_locked;

  logic               w_vld;
  logic [2:0]         w_idx;
  logic [3:0]         w_best;
  logic [3:0]         w_dist;
  logic               w_lk_req;
  logic               w_lk_lock;
  logic               w_sel_lock;
  logic [WIDTH-1:0]   w_wd;
  logic [NUM_REQ-1:0] w_gnt;

  function automatic logic [2:0] f_next(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  always_comb begin
    w_vld      = 1'b0;
    w_idx      = 3'd0;
    w_best     = 4'hF;
    w_dist     = 4'd0;
    w_lk_req   = 1'b0;
    w_lk_lock  = 1'b0;
    w_sel_lock = 1'b0;
    w_wd       = '0;
    w_gnt      = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == r_lk_id) begin
        w_lk_req  = bus.req[i];
        w_lk_lock = bus.lock[i];
      end
    end

    if (r_state == ST_LOCKED) begin
      w_vld = w_lk_req;
      w_idx = r_lk_id;
    end else begin
      // Pick the requester closest to ptr going upward with wrap.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (3'(i) >= r_ptr) w_dist = 4'(i) - {1'b0, r_ptr};
        else                w_dist = 4'(i) + 4'(NUM_REQ) - {1'b0, r_ptr};
        if (bus.req[i] && (w_dist < w_best)) begin
          w_best = w_dist;
          w_idx  = 3'(i);
          w_vld  = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == 3'(i)) begin
        w_sel_lock = bus.lock[i];
        w_wd       = bus.wdata[i*WIDTH +: WIDTH];
        w_gnt[i]   = w_vld && !rst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 3'd0;
      r_hold   <= 4'd0;
      r_lk_id  <= 3'd0;
      r_out    <= INIT;
      r_owner  <= 3'd0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      if (w_vld) begin
        r_out   <= w_wd;
        r_owner <= w_idx;
        r_valid <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            if (w_sel_lock && (MAX_HOLD > 1)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_lk_id  <= w_idx;
              r_hold   <= 4'd1;
            end else begin
              r_ptr <= f_next(w_idx);
            end
          end
        end
        ST_LOCKED: begin
          // Release moves ptr past the holder so it cannot relock ahead of others.
          if (!w_lk_req || !w_lk_lock || ((r_hold + 4'd1) == 4'(MAX_HOLD))) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_ptr    <= f_next(r_lk_id);
            r_hold   <= 4'd0;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.out         = r_out;
  assign bus.owner       = r_owner;
  assign bus.owner_valid = r_valid;
  assign bus.locked      = r_locked;

endmodule

`default_nettype wire
